// File: rtl/par3_to_serial_requant.sv
// Requantises 3-lane blocks from the parallel FIR to OUT_W-bit samples,
// buffers them in a block FIFO and drains them as one serial sample stream.
module par3_to_serial_requant #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  din1,
    input  logic signed [IN_W-1:0]  din2,
    input  logic signed [IN_W-1:0]  din3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] dout,
    output logic [15:0]             sat_cnt,
    output logic                    sat_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [IN_W:0] HALF =
        {{(IN_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [IN_W:0] MAX_R = (IN_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] MIN_R = -MAX_R - 1;

    logic signed [IN_W-1:0] din_lane [3];
    logic [OUT_W-1:0]       q_lane   [3];
    logic [OUT_W-1:0]       rd_lane  [3];
    logic [2:0]             sat_lane;

    logic [AW:0]            wptr_reg;
    logic [AW:0]            rptr_reg;
    logic [1:0]             lane_reg;
    logic [3*OUT_W-1:0]     mem [DEPTH];
    logic [3*OUT_W-1:0]     rd_entry;

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   take;
    logic                   pop;
    logic [1:0]             nsat;
    logic [16:0]            sat_sum;

    assign din_lane[0] = din1;
    assign din_lane[1] = din2;
    assign din_lane[2] = din3;

    // One extra bit of headroom keeps the rounding add from wrapping at full scale.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] r;
        assign sum          = {din_lane[gi][IN_W-1], din_lane[gi]} + HALF;
        assign r            = sum >>> SHIFT;
        assign sat_lane[gi] = (r > MAX_R) || (r < MIN_R);
        assign q_lane[gi]   = (r > MAX_R) ? OUT_W'(MAX_R) :
                              (r < MIN_R) ? OUT_W'(MIN_R) : r[OUT_W-1:0];
        assign rd_lane[gi]  = rd_entry[gi*OUT_W +: OUT_W];
    end

    assign empty     = (wptr_reg == rptr_reg);
    assign full      = (wptr_reg[AW] != rptr_reg[AW]) &&
                       (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign pop       = take && (lane_reg == 2'd2);

    assign nsat    = 2'(sat_lane[0]) + 2'(sat_lane[1]) + 2'(sat_lane[2]);
    assign sat_sum = {1'b0, sat_cnt} + 17'(nsat);

    // Storage has no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg[AW-1:0]] <= {q_lane[2], q_lane[1], q_lane[0]};
        end
    end

    assign rd_entry = mem[rptr_reg[AW-1:0]];

    always_comb begin
        dout = '0;
        if (!empty) begin
            case (lane_reg)
                2'd0:    dout = rd_lane[0];
                2'd1:    dout = rd_lane[1];
                default: dout = rd_lane[2];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            lane_reg <= '0;
            sat_cnt  <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + 1'b1;
                sat_cnt  <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
                sat_flag <= sat_flag | (nsat != 2'd0);
            end
            if (take) begin
                lane_reg <= pop ? 2'd0 : lane_reg + 2'd1;
            end
            if (pop) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_par3_to_serial_requant.sv
// Scoreboard bench: accepted blocks are requantised by a floor-division model
// into an expected-sample queue that a negedge monitor checks against dout.
module tb_par3_to_serial_requant;
    localparam int IN_W  = 64;
    localparam int OUT_W = 16;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  din1;
    logic signed [IN_W-1:0]  din2;
    logic signed [IN_W-1:0]  din3;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] dout;
    logic [15:0]             sat_cnt;
    logic                    sat_flag;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int sat_exp = 0;
    int flag_exp = 0;
    int verbose = 1;
    int n_out = 0;

    par3_to_serial_requant dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .din1(din1), .din2(din2), .din3(din3),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .sat_cnt(sat_cnt), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Round-half-up of x / 2^15 via floor division plus remainder test.
    function automatic longint rq_raw(input longint x);
        longint q;
        longint rem;
        q   = x >>> 15;
        rem = x & 64'sd32767;
        return (rem >= 64'sd16384) ? q + 1 : q;
    endfunction

    task automatic model_push(input longint a, input longint b, input longint c);
        longint v [3];
        longint r;
        int     ns;
        v[0] = a; v[1] = b; v[2] = c;
        ns = 0;
        for (int i = 0; i < 3; i++) begin
            r = rq_raw(v[i]);
            if (r > 32767) begin r = 32767; ns++; end
            else if (r < -32768) begin r = -32768; ns++; end
            exp_q.push_back(int'(r));
        end
        sat_exp = (sat_exp + ns > 65535) ? 65535 : sat_exp + ns;
        if (ns > 0) flag_exp = 1;
        if (verbose != 0)
            $display("IN  block %0d %0d %0d -> sat lanes %0d", a, b, c, ns);
    endtask

    function automatic longint rnd_val();
        longint v;
        case ($urandom_range(0, 3))
            0: v = longint'(int'($urandom)) >>> 2;
            1: v = longint'(int'($urandom));
            2: v = longint'({$urandom, $urandom});
            default: begin
                if ($urandom_range(0, 1) == 0)
                    v = 64'sd1073725440 + longint'($urandom_range(0, 65535)) - 64'sd32768;
                else
                    v = -64'sd1073758208 + longint'($urandom_range(0, 65535)) - 64'sd32768;
            end
        endcase
        return v;
    endfunction

    initial forever begin
        @(negedge clk);
        if (rst && in_valid && in_ready) model_push(din1, din2, din3);
    end

    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %0d, expected no sample", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", longint'(dout), longint'(e));
                    if (verbose != 0) $display("OUT sample %0d: dout=%0d exp=%0d", n_out, dout, e);
                end
                n_out++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input longint a, input longint b, input longint c);
        logic hs;
        hs = 1'b0;
        in_valid = 1'b1;
        din1 = a; din2 = b; din3 = c;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk);
            hs = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accepted", longint'(hs), 1);
    endtask

    task automatic drain(input int bound);
        out_ready = 1'b1;
        for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_out_valid", longint'(out_valid), 0);
    endtask

    initial begin
        int   acc;
        int   drained;
        int   sent;
        logic hs;
        logic done5;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        din1 = '0; din2 = '0; din3 = '0;

        // Input burst while held in reset must be ignored.
        in_valid = 1'b1;
        din1 = 64'sd1 <<< 40; din2 = 64'sd99999; din3 = -64'sd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_in_ready", longint'(in_ready), 1);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_dout", longint'(dout), 0);
            chk("rst_sat_cnt", longint'(sat_cnt), 0);
            chk("rst_sat_flag", longint'(sat_flag), 0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_out_valid", longint'(out_valid), 0);

        // Rounding: expected 1, 1, 0, -1, 1, 0.
        out_ready = 1'b1;
        send_block(64'sd32768, 64'sd16384, -64'sd16384);
        send_block(-64'sd16385, 64'sd49151, 64'sd0);
        drain(50);
        chk("round_sat_cnt", longint'(sat_cnt), longint'(sat_exp));
        chk("round_sat_flag", longint'(sat_flag), 0);

        // Saturation including the most positive input.
        send_block(64'sd1 <<< 40, -(64'sd1 <<< 40), 64'sh7FFF_FFFF_FFFF_FFFF);
        drain(50);
        chk("sat_cnt", longint'(sat_cnt), longint'(sat_exp));
        chk("sat_flag", longint'(sat_flag), longint'(flag_exp));

        // Backpressure: fill to four blocks, fifth waits for the first pop.
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        din1 = rnd_val(); din2 = rnd_val(); din3 = rnd_val();
        for (int c = 0; c < 12 && acc < 4; c++) begin
            @(negedge clk);
            hs = in_ready;
            tick();
            if (hs) begin
                acc++;
                din1 = rnd_val(); din2 = rnd_val(); din3 = rnd_val();
            end
        end
        repeat (3) tick();
        chk("bp_accepted", acc, 4);
        chk("bp_in_ready", longint'(in_ready), 0);
        chk("bp_out_valid", longint'(out_valid), 1);
        out_ready = 1'b1;
        drained = 0;
        done5 = 1'b0;
        for (int c = 0; c < 20 && !done5; c++) begin
            @(negedge clk);
            if (in_ready) begin
                chk("bp_fifth_after_pop", longint'(drained >= 3), 1);
                done5 = 1'b1;
            end
            if (out_valid && out_ready) drained++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_fifth_accepted", longint'(done5), 1);
        drain(100);

        // Random out_ready with continuous input.
        verbose = 0;
        sent = 0;
        in_valid = 1'b1;
        din1 = rnd_val(); din2 = rnd_val(); din3 = rnd_val();
        for (int c = 0; c < 40000 && sent < 3000; c++) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            tick();
            out_ready = ($urandom_range(0, 3) != 0);
            if (hs) begin
                sent++;
                if (sent < 3000) begin
                    din1 = rnd_val(); din2 = rnd_val(); din3 = rnd_val();
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        chk("rand_blocks_sent", sent, 3000);
        drain(200);
        chk("rand_sat_cnt", longint'(sat_cnt), longint'(sat_exp));
        chk("rand_sat_flag", longint'(sat_flag), longint'(flag_exp));

        // Reset after lane 1 of a block has been taken.
        verbose = 1;
        out_ready = 1'b0;
        send_block(64'sd100000, 64'sd200000, 64'sd300000);
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        exp_q.delete();
        sat_exp = 0;
        flag_exp = 0;
        #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_dout", longint'(dout), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        chk("mid_rst_sat_cnt", longint'(sat_cnt), 0);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("mid_rst_no_stale", longint'(out_valid), 0);
        out_ready = 1'b1;
        send_block(-64'sd700000, 64'sd65536, 64'sd1 <<< 50);
        drain(50);
        chk("mid_rst_sat_cnt_after", longint'(sat_cnt), longint'(sat_exp));

        chk("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/par3_to_serial_requant.md
Name: par3_to_serial_requant

Overview:
- Output stage directly downstream of the three-parallel FIR. Consumes one 3-lane block per handshake (dout1/dout2/dout3 of the filter, 64-bit each).
- Requantises each lane to 16-bit signed using round-half-up and saturation.
- Buffers blocks in a small FIFO and drains them as a single-sample serial stream in time order, for the DAC/capture side.
- Single clock domain, valid/ready on both sides.

Parameters:
- IN_W, 64: input lane width, signed.
- OUT_W, 16: output sample width, signed.
- SHIFT, 15: right-shift applied during requantisation. Range 1..IN_W-OUT_W.
- DEPTH, 4: FIFO depth in blocks. Power of two, >= 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  the block on din1..din3 is valid.
- in_ready  out  1  the block is accepted when in_valid && in_ready at the rising edge.
- din1  in  IN_W  lane 0, oldest sample of the block (time n).
- din2  in  IN_W  lane 1 (time n+1).
- din3  in  IN_W  lane 2 (time n+2).
- out_valid  out  1  dout holds a valid sample.
- out_ready  in  1  the sink accepts dout when out_valid && out_ready.
- dout  out  OUT_W  serial requantised sample.
- sat_cnt  out  16  count of saturated lanes in accepted blocks; saturates at 0xFFFF.
- sat_flag  out  1  sticky; set on the first saturated lane, cleared only by reset.

Behaviour:
- Reset (rst low, asynchronous): FIFO empty; write pointer, read pointer and lane counter = 0; in_ready = 1; out_valid = 0; dout = 0; sat_cnt = 0; sat_flag = 0. FIFO contents are don't-care.
- Reset asserted mid-operation discards all buffered blocks and any partially drained block. After deassertion, no stale sample may appear on dout.
- Requantisation, per lane, combinational on the write path:
  - r = (x + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits so the addition never wraps.
  - If r > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1 (sat). If r < -2^(OUT_W-1), output -2^(OUT_W-1) (sat). Otherwise output r[OUT_W-1:0].
  - The FIFO stores 3*OUT_W bits per entry.
- Input side:
  - in_ready = !full. No same-cycle bypass: a pop in the same cycle does not raise in_ready.
  - On accept: write the entry; wptr += 1 modulo DEPTH; sat_cnt += (number of saturated lanes, 0..3), clamped at 0xFFFF; sat_flag |= any lane saturated.
  - Full/empty are tracked with one extra pointer bit (wrap bit).
- Output side:
  - out_valid = !empty.
  - dout = lane[lane_cnt] of the entry at rptr; driven as 0 when empty.
  - On out_valid && out_ready: if lane_cnt < 2, lane_cnt += 1; if lane_cnt == 2, lane_cnt = 0 and rptr += 1 (pop).
  - Lane order is always din1, din2, din3.
  - When out_ready is low, dout and lane_cnt hold.
- Simultaneous push and pop in one cycle: both take effect. Occupancy is unchanged.
- Latency: a block accepted at edge k gives out_valid = 1 from after edge k when the FIFO was empty. Its lane-0 sample is presented on dout in that cycle.
- Throughput: 1 sample/cycle out. Sustained input is limited to one block per 3 cycles.

Test Plan:
- Reset check: rst low, then a burst of in_valid -> in_ready = 1, out_valid = 0, dout = 0, sat_cnt = 0. Nothing is accepted while rst is low.
- Rounding block, SHIFT = 15: din1 = 32768, din2 = 16384, din3 = -16384, then a second block -16385, 49151, 0 -> dout sequence 1, 1, 0, -1, 1, 0. sat_cnt = 0.
- Saturation: din1 = 2^40, din2 = -2^40, din3 = 0x7FFF_FFFF_FFFF_FFFF -> dout sequence 32767, -32768, 32767. sat_cnt = 3, sat_flag = 1. The rounding add must not wrap.
- Backpressure: out_ready = 0, offer 5 blocks -> 4 accepted, in_ready = 0 after the 4th. Then out_ready = 1 -> 12 samples in order, each block's lanes contiguous. The 5th block is accepted only after the first pop.
- Random out_ready with continuous input: output sequence equals the requantised input stream in time order, with no drop or duplicate. Check against a scoreboard over 3000 blocks.
- Mid-drain reset: pulse rst low after lane 1 of a block -> out_valid = 0 immediately. After release, the next accepted block's lane 0 is the first output.
